// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters for issue/writeback scoreboarding.
// Optional same-cycle writeback-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int LEN_REG = 32,
  parameter int NUM_REG = 16,
  parameter int NUM_RD  = 2,
  parameter int PEND_W  = 2,
  localparam int AW     = $clog2(NUM_REG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*AW-1:0]      rd_addr_i,
  output logic [NUM_RD*LEN_REG-1:0] rd_data_o,
  output logic [NUM_RD-1:0]         rd_busy_o,
  input  logic                      rsv_valid_i,
  input  logic [AW-1:0]             rsv_addr_i,
  output logic                      rsv_ready_o,
  input  logic                      wb_valid_i,
  input  logic [AW-1:0]             wb_addr_i,
  input  logic [LEN_REG-1:0]        wb_data_i,
  output logic [NUM_REG-1:0]        busy_o,
  output logic                      err_o
);

  localparam logic [PEND_W-1:0] MAX_PEND = '1;

  logic [LEN_REG-1:0] data_q  [NUM_REG];
  logic [PEND_W-1:0]  cnt_q   [NUM_REG];
  logic [PEND_W-1:0]  cnt_nxt [NUM_REG];
  logic [NUM_REG-1:0] busy_q;
  logic               err_q;
  logic               rsv_fire;
  logic               underflow;

  // A reserve and a writeback to the same register cancel; a writeback never takes cnt below 0.
  function automatic logic [PEND_W-1:0] cnt_update(input logic [PEND_W-1:0] cnt,
                                                   input logic inc, input logic dec);
    if (inc && !dec)
      return cnt + 1'b1;
    if (dec && !inc && cnt != '0)
      return cnt - 1'b1;
    return cnt;
  endfunction

  always_comb begin
    rsv_ready_o = (cnt_q[rsv_addr_i] != MAX_PEND) || (wb_valid_i && wb_addr_i == rsv_addr_i);
    rsv_fire    = rsv_valid_i && rsv_ready_o;
    underflow   = wb_valid_i && (cnt_q[wb_addr_i] == '0) &&
                  !(rsv_fire && rsv_addr_i == wb_addr_i);
    for (int i = 0; i < NUM_REG; i++) begin
      cnt_nxt[i] = cnt_update(cnt_q[i],
                              rsv_fire && (rsv_addr_i == AW'(i)),
                              wb_valid_i && (wb_addr_i == AW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REG; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) begin
        cnt_q[i]  <= cnt_nxt[i];
        busy_q[i] <= (cnt_nxt[i] != '0);
      end
      if (wb_valid_i)
        data_q[wb_addr_i] <= wb_data_i;
      if (underflow)
        err_q <= 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    // A same-cycle writeback satisfies one outstanding write; busy only if more remain.
    logic hit;
    assign hit = wb_valid_i && (wb_addr_i == addr);
    assign rd_data_o[k*LEN_REG +: LEN_REG] = hit ? wb_data_i : data_q[addr];
    assign rd_busy_o[k] = hit ? (cnt_q[addr] > PEND_W'(1)) : (cnt_q[addr] != '0);
`else
    assign rd_data_o[k*LEN_REG +: LEN_REG] = data_q[addr];
    assign rd_busy_o[k] = (cnt_q[addr] != '0);
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario bench for regfile_scoreboard; read-port expectations go through a queue scoreboard.
// Adapts expected read values when REGFILE_BYPASS_EN is defined.
module tb_regfile_scoreboard;
  localparam int LEN_REG = 32;
  localparam int NUM_REG = 16;
  localparam int NUM_RD  = 2;
  localparam int PEND_W  = 2;
  localparam int AW      = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_RD*AW-1:0]      rd_addr_i = '0;
  logic [NUM_RD*LEN_REG-1:0] rd_data_o;
  logic [NUM_RD-1:0]         rd_busy_o;
  logic                      rsv_valid_i = 1'b0;
  logic [AW-1:0]             rsv_addr_i = '0;
  logic                      rsv_ready_o;
  logic                      wb_valid_i = 1'b0;
  logic [AW-1:0]             wb_addr_i = '0;
  logic [LEN_REG-1:0]        wb_data_i = '0;
  logic [NUM_REG-1:0]        busy_o;
  logic                      err_o;

  regfile_scoreboard #(
    .LEN_REG(LEN_REG), .NUM_REG(NUM_REG), .NUM_RD(NUM_RD), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i), .rsv_ready_o(rsv_ready_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 4'd3;
    rd_addr_i   = {4'd3, 4'd3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy_o !== 16'h0) $display("FAIL reset_busy: got %h expected 0000", busy_o); else n_pass++;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_o); else n_pass++;
    n_checks++;
    if (rd_data_o !== 64'h0) $display("FAIL reset_rd_data: got %h expected 0", rd_data_o); else n_pass++;
    n_checks++;
    if (rsv_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", rsv_ready_o); else n_pass++;
    n_checks++;
    if (rd_busy_o !== 2'b00) $display("FAIL reset_rd_busy: got %b expected 00", rd_busy_o); else n_pass++;
    rsv_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    // mid-operation reset discards a live reservation asynchronously
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 4'd1;
    rd_addr_i   = {4'd1, 4'd1};
    tick();
    rsv_valid_i = 1'b0;
    n_checks++;
    if (busy_o !== 16'h0002) $display("FAIL midrst_pre_busy: got %h expected 0002", busy_o); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 16'h0) $display("FAIL midrst_busy: got %h expected 0000", busy_o); else n_pass++;
    n_checks++;
    if (rd_busy_o !== 2'b00) $display("FAIL midrst_rd_busy: got %b expected 00", rd_busy_o); else n_pass++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reserve_wb();
    rd_addr_i   = {4'd3, 4'd3};
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 4'd3;
    @(negedge clk);
    n_checks++;
    if (rsv_ready_o !== 1'b1) $display("FAIL rw_ready: got %b expected 1", rsv_ready_o); else n_pass++;
    tick();
    rsv_valid_i = 1'b0;
    n_checks++;
    if (busy_o !== 16'h0008) $display("FAIL rw_busy_set: got %h expected 0008", busy_o); else n_pass++;
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd3;
    wb_data_i  = 32'hDEADBEEF;
    exp_q.push_back('{"rw_wbcycle_data", BYP ? 64'hDEADBEEF : 64'h0});
    exp_q.push_back('{"rw_wbcycle_busy", BYP ? 64'h0 : 64'h3});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (64'(rd_data_o[31:0]) !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o[31:0], e.val); else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (64'(rd_busy_o) !== e.val) $display("FAIL %s: got %b expected %0h", e.name, rd_busy_o, e.val); else n_pass++;
    tick();
    wb_valid_i = 1'b0;
    n_checks++;
    if (busy_o !== 16'h0) $display("FAIL rw_busy_clr: got %h expected 0000", busy_o); else n_pass++;
    exp_q.push_back('{"rw_after_data", 64'hDEADBEEF_DEADBEEF});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data_o !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o, e.val); else n_pass++;
    n_checks++;
    if (rd_busy_o !== 2'b00) $display("FAIL rw_after_busy: got %b expected 00", rd_busy_o); else n_pass++;
    tick();
  endtask

  task automatic test_waw_limit();
    rd_addr_i = {4'd5, 4'd5};
    for (int i = 0; i < 4; i++) begin
      rsv_valid_i = 1'b1;
      rsv_addr_i  = 4'd5;
      @(negedge clk);
      n_checks++;
      if (rsv_ready_o !== (i < 3)) $display("FAIL waw_ready%0d: got %b expected %b", i, rsv_ready_o, (i < 3)); else n_pass++;
      tick();
    end
    rsv_valid_i = 1'b0;
    n_checks++;
    if (busy_o !== 16'h0020) $display("FAIL waw_busy: got %h expected 0020", busy_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wb_valid_i = 1'b1;
      wb_addr_i  = 4'd5;
      wb_data_i  = 32'(100 + i);
      tick();
      n_checks++;
      if (busy_o[5] !== (i < 2)) $display("FAIL waw_wb%0d_busy: got %b expected %b", i, busy_o[5], (i < 2)); else n_pass++;
    end
    wb_valid_i = 1'b0;
    exp_q.push_back('{"waw_data", {32'd102, 32'd102}});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data_o !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o, e.val); else n_pass++;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL waw_err: got %b expected 0", err_o); else n_pass++;
    tick();
  endtask

  task automatic test_simul_full();
    rd_addr_i   = {4'd7, 4'd7};
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 4'd7;
    repeat (3) tick();
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd7;
    wb_data_i  = 32'h77;
    @(negedge clk);
    n_checks++;
    if (rsv_ready_o !== 1'b1) $display("FAIL full_simul_ready: got %b expected 1", rsv_ready_o); else n_pass++;
    tick();
    wb_valid_i = 1'b0;
    exp_q.push_back('{"full_data", 64'h77});
    @(negedge clk);
    n_checks++;
    if (rsv_ready_o !== 1'b0) $display("FAIL full_cnt_kept: got %b expected 0", rsv_ready_o); else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (64'(rd_data_o[31:0]) !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o[31:0], e.val); else n_pass++;
    tick();
    rsv_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_valid_i = 1'b1;
      wb_addr_i  = 4'd7;
      wb_data_i  = 32'h700 + 32'(i);
      tick();
      n_checks++;
      if (busy_o[7] !== (i < 2)) $display("FAIL full_wb%0d_busy: got %b expected %b", i, busy_o[7], (i < 2)); else n_pass++;
    end
    wb_valid_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL full_err: got %b expected 0", err_o); else n_pass++;
  endtask

  task automatic test_underflow();
    rd_addr_i  = {4'd2, 4'd2};
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd2;
    wb_data_i  = 32'h12;
    exp_q.push_back('{"uf_wbcycle_data", BYP ? 64'h12 : 64'h0});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (64'(rd_data_o[31:0]) !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o[31:0], e.val); else n_pass++;
    n_checks++;
    if (rd_busy_o !== 2'b00) $display("FAIL uf_rd_busy: got %b expected 00", rd_busy_o); else n_pass++;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL uf_err_before: got %b expected 0", err_o); else n_pass++;
    tick();
    wb_valid_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL uf_err_set: got %b expected 1", err_o); else n_pass++;
    n_checks++;
    if (busy_o !== 16'h0) $display("FAIL uf_busy: got %h expected 0000", busy_o); else n_pass++;
    exp_q.push_back('{"uf_data", {32'h12, 32'h12}});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data_o !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o, e.val); else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL uf_err_sticky: got %b expected 1", err_o); else n_pass++;
  endtask

  task automatic test_multi_read();
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 4'd9;
    tick();
    rsv_valid_i = 1'b0;
    rd_addr_i   = {4'd9, 4'd9};
    wb_valid_i  = 1'b1;
    wb_addr_i   = 4'd9;
    wb_data_i   = 32'hA5A50009;
    exp_q.push_back('{"mr_wbcycle_data", BYP ? 64'hA5A50009_A5A50009 : 64'h0});
    exp_q.push_back('{"mr_wbcycle_busy", BYP ? 64'h0 : 64'h3});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data_o !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o, e.val); else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (64'(rd_busy_o) !== e.val) $display("FAIL %s: got %b expected %0h", e.name, rd_busy_o, e.val); else n_pass++;
    tick();
    wb_valid_i = 1'b0;
    exp_q.push_back('{"mr_after_data", 64'hA5A50009_A5A50009});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data_o !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_o, e.val); else n_pass++;
    n_checks++;
    if (busy_o !== 16'h0) $display("FAIL mr_busy: got %h expected 0000", busy_o); else n_pass++;
    tick();
  endtask

  task automatic test_reset_clears();
    rd_addr_i = {4'd9, 4'd2};
    rst = 1'b0;
    #1;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL rst2_err: got %b expected 0", err_o); else n_pass++;
    n_checks++;
    if (rd_data_o !== 64'h0) $display("FAIL rst2_data: got %h expected 0", rd_data_o); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reserve_wb();
    test_waw_limit();
    test_simul_full();
    test_underflow();
    test_multi_read();
    test_reset_clears();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
